// File: rtl/brk_pkg.sv
// Shared constants and helpers for the data-break arbiter.
// State encoding, device count and bus widths live here.
package brk_pkg;

    localparam int NDEV          = 2;
    localparam int AW            = 15;
    localparam int DW            = 12;
    localparam int BURST_MAX_DEF = 4;
    localparam int IDXW          = 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef logic [NDEV-1:0] dev_vec_t;

    // One-hot device vector to device index.
    function automatic logic [IDXW-1:0] oh2idx(input dev_vec_t oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NDEV; i++)
            if (oh[i]) idx = IDXW'(i);
        return idx;
    endfunction

endpackage

// File: rtl/brk_prio.sv
// Combinational winner picker for data-break requests.
// Fixed priority (device 0 first) unless BRK_RR_EN selects round-robin.
import brk_pkg::*;

module brk_prio (
    input  logic [NDEV-1:0] req,
`ifdef BRK_RR_EN
    input  logic [IDXW-1:0] ptr,
`endif
    output logic [NDEV-1:0] win
);

`ifdef BRK_RR_EN
    // Scan from the pointer upward; later loop passes override, so the
    // pointer position itself ends up with the highest priority.
    always_comb begin
        win = '0;
        for (int k = NDEV - 1; k >= 0; k--)
            for (int i = 0; i < NDEV; i++)
                if (req[i] && i == (int'(ptr) + k) % NDEV) begin
                    win    = '0;
                    win[i] = 1'b1;
                end
    end
`else
    // Lowest-numbered requester wins.
    always_comb begin
        win = '0;
        for (int i = NDEV - 1; i >= 0; i--)
            if (req[i]) begin
                win    = '0;
                win[i] = 1'b1;
            end
    end
`endif

endmodule

// File: rtl/break_arbiter.sv
// Data-break arbiter: steals memory cycles for devices between CPU states.
// Optional macro BRK_RR_EN switches the picker to round-robin.
import brk_pkg::*;

module break_arbiter #(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            cycle_end,
    input  logic [NDEV-1:0] req,
    input  logic [NDEV-1:0] dir,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW-1:0]   wdata1,
    input  logic [DW-1:0]   mdout,
    output logic [NDEV-1:0] grant,
    output logic            break_in_prog,
    output logic            to_mem,
    output logic [AW-1:0]   dmaAddr,
    output logic [DW-1:0]   dmaDOUT,
    output logic [DW-1:0]   rdata,
    output logic [NDEV-1:0] done
);

    localparam int CW = $clog2(BURST_MAX + 1);

    logic [1:0]      state;
    logic [NDEV-1:0] win;
    logic            dir_q;
    logic [CW-1:0]   burst_cnt;
    logic            guard;
    logic            start;

`ifdef BRK_RR_EN
    logic [IDXW-1:0] ptr;

    brk_prio u_prio (
        .req (req),
        .ptr (ptr),
        .win (win)
    );

    // Move the round-robin pointer past the device just served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (state == S_DONE) begin
            if (int'(oh2idx(grant)) == NDEV - 1)
                ptr <= '0;
            else
                ptr <= oh2idx(grant) + IDXW'(1);
        end
    end
`else
    brk_prio u_prio (
        .req (req),
        .win (win)
    );
`endif

    assign guard = (burst_cnt == CW'(BURST_MAX));
    assign start = (state == S_IDLE) && cycle_end && (|req)
                   && !guard && !clear;

    // Break sequencer: IDLE waits, then ADDR, XFER, DONE one cycle each.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else begin
            unique case (state)
                S_IDLE:  if (start) state <= S_ADDR;
                S_ADDR:  state <= S_XFER;
                S_XFER:  state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Latch winner, direction, address and data when a break starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant   <= '0;
            dir_q   <= 1'b0;
            dmaAddr <= '0;
            dmaDOUT <= '0;
        end else if (start) begin
            grant   <= win;
            dir_q   <= |(dir & win);
            dmaAddr <= win[1] ? addr1 : addr0;
            dmaDOUT <= win[1] ? wdata1 : wdata0;
        end else if (state == S_DONE) begin
            grant   <= '0;
        end
    end

    // Capture memory read data at the end of a read transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdata <= '0;
        else if (state == S_XFER && !dir_q)
            rdata <= mdout;
    end

    // Count back-to-back breaks; a guarded IDLE cycle resets the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            burst_cnt <= '0;
        else if (start)
            burst_cnt <= burst_cnt + CW'(1);
        else if (state == S_IDLE)
            burst_cnt <= '0;
    end

    assign break_in_prog = (state == S_ADDR) || (state == S_XFER);
    assign to_mem        = (state == S_XFER) && dir_q;
    assign done          = (state == S_DONE) ? grant : '0;

endmodule

// File: tb/tb_break_arbiter.sv
// Scoreboard bench for break_arbiter: stimulus queues expected completions,
// a monitor pops and checks them whenever done pulses.
`timescale 1ns/1ps

module tb_break_arbiter;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        cycle_end;
    logic [1:0]  req;
    logic [1:0]  dir;
    logic [14:0] addr0;
    logic [14:0] addr1;
    logic [11:0] wdata0;
    logic [11:0] wdata1;
    logic [11:0] mdout;
    logic [1:0]  grant;
    logic        break_in_prog;
    logic        to_mem;
    logic [14:0] dmaAddr;
    logic [11:0] dmaDOUT;
    logic [11:0] rdata;
    logic [1:0]  done;

    typedef struct {
        logic [1:0]  dn;
        logic [14:0] ad;
        logic [11:0] wd;
        logic [11:0] rd;
        int          cy;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   m;

    break_arbiter #(.BURST_MAX(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .cycle_end     (cycle_end),
        .req           (req),
        .dir           (dir),
        .addr0         (addr0),
        .addr1         (addr1),
        .wdata0        (wdata0),
        .wdata1        (wdata1),
        .mdout         (mdout),
        .grant         (grant),
        .break_in_prog (break_in_prog),
        .to_mem        (to_mem),
        .dmaAddr       (dmaAddr),
        .dmaDOUT       (dmaDOUT),
        .rdata         (rdata),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [1:0] dn, input logic [14:0] ad,
                        input logic [11:0] wd, input logic [11:0] rd,
                        input int cy);
        exp_t e;
        e.dn = dn;
        e.ad = ad;
        e.wd = wd;
        e.rd = rd;
        e.cy = cy;
        sbq.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest expected completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done !== 2'b00) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", {30'd0, done}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("done_vec", {30'd0, done}, {30'd0, e.dn});
                    check("done_addr", {17'd0, dmaAddr}, {17'd0, e.ad});
                    check("done_dout", {20'd0, dmaDOUT}, {20'd0, e.wd});
                    check("done_rdata", {20'd0, rdata}, {20'd0, e.rd});
                    check("done_cycle", cyc, e.cy);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        cycle_end = 1'b0;
        req       = 2'b00;
        dir       = 2'b00;
        addr0     = '0;
        addr1     = '0;
        wdata0    = '0;
        wdata1    = '0;
        mdout     = '0;
        tick(3);
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_bip", {31'd0, break_in_prog}, 32'd0);
        check("rst_to_mem", {31'd0, to_mem}, 32'd0);
        check("rst_done", {30'd0, done}, 32'd0);
        check("rst_addr", {17'd0, dmaAddr}, 32'd0);
        check("rst_dout", {20'd0, dmaDOUT}, 32'd0);
        check("rst_rdata", {20'd0, rdata}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Single write from device 0.
        m = cyc;
        req = 2'b01; dir = 2'b01; addr0 = 15'h1234; wdata0 = 12'o7070;
        cycle_end = 1'b1;
        push(2'b01, 15'h1234, 12'o7070, 12'o0000, m + 3);
        tick(1);
        cycle_end = 1'b0; req = 2'b00;
        check("w_addr_grant", {30'd0, grant}, 32'd1);
        check("w_addr_bip", {31'd0, break_in_prog}, 32'd1);
        check("w_addr_to_mem", {31'd0, to_mem}, 32'd0);
        tick(1);
        check("w_xfer_grant", {30'd0, grant}, 32'd1);
        check("w_xfer_bip", {31'd0, break_in_prog}, 32'd1);
        check("w_xfer_to_mem", {31'd0, to_mem}, 32'd1);
        check("w_xfer_addr", {17'd0, dmaAddr}, 32'h1234);
        check("w_xfer_dout", {20'd0, dmaDOUT}, 32'(12'o7070));
        tick(1);
        check("w_done_bip", {31'd0, break_in_prog}, 32'd0);
        check("w_done_to_mem", {31'd0, to_mem}, 32'd0);
        tick(1);
        check("w_idle_grant", {30'd0, grant}, 32'd0);
        tick(3);

        // Both devices request reads with cycle_end held.
        addr0 = 15'h0100; addr1 = 15'h0200;
        wdata0 = 12'o1000; wdata1 = 12'o2000;
        mdout = 12'o1111; dir = 2'b00;
        m = cyc;
        req = 2'b11; cycle_end = 1'b1;
        push(2'b01, 15'h0100, 12'o1000, 12'o1111, m + 3);
        push(2'b10, 15'h0200, 12'o2000, 12'o1111, m + 7);
`ifdef BRK_RR_EN
        push(2'b01, 15'h0100, 12'o1000, 12'o1111, m + 11);
        tick(11);
`else
        tick(3);
        req = 2'b10;
        tick(4);
`endif
        req = 2'b00; cycle_end = 1'b0;
        tick(4);

        // Held request: four breaks, one refused IDLE, then resume.
        addr0 = 15'h0300; mdout = 12'o3333;
        m = cyc;
        req = 2'b01; cycle_end = 1'b1;
        push(2'b01, 15'h0300, 12'o1000, 12'o3333, m + 3);
        push(2'b01, 15'h0300, 12'o1000, 12'o3333, m + 7);
        push(2'b01, 15'h0300, 12'o1000, 12'o3333, m + 11);
        push(2'b01, 15'h0300, 12'o1000, 12'o3333, m + 15);
        push(2'b01, 15'h0300, 12'o1000, 12'o3333, m + 20);
        tick(16);
        check("burst_refuse_bip", {31'd0, break_in_prog}, 32'd0);
        tick(4);
        req = 2'b00; cycle_end = 1'b0;
        tick(4);

        // Device 1 read.
        addr1 = 15'h0200; mdout = 12'o5252;
        m = cyc;
        req = 2'b10; cycle_end = 1'b1;
        push(2'b10, 15'h0200, 12'o2000, 12'o5252, m + 3);
        tick(1);
        req = 2'b00; cycle_end = 1'b0;
        tick(4);

        // Clear during ADDR: write still completes, rdata untouched.
        m = cyc;
        req = 2'b01; dir = 2'b01; addr0 = 15'h7FFF; wdata0 = 12'o0007;
        cycle_end = 1'b1;
        push(2'b01, 15'h7FFF, 12'o0007, 12'o5252, m + 3);
        tick(1);
        clear = 1'b1; cycle_end = 1'b0; req = 2'b00;
        addr0 = 15'h0000; wdata0 = 12'o0000;
        tick(1);
        clear = 1'b0;
        check("clr_xfer_to_mem", {31'd0, to_mem}, 32'd1);
        check("clr_xfer_addr", {17'd0, dmaAddr}, 32'h7FFF);
        tick(4);

        // Clear in IDLE blocks that cycle's grant only.
        dir = 2'b00; addr0 = 15'h0042; wdata0 = 12'o0011; mdout = 12'o0123;
        req = 2'b01; cycle_end = 1'b1; clear = 1'b1;
        tick(1);
        check("clr_idle_bip", {31'd0, break_in_prog}, 32'd0);
        clear = 1'b0;
        m = cyc;
        push(2'b01, 15'h0042, 12'o0011, 12'o0123, m + 3);
        tick(3);
        req = 2'b00; cycle_end = 1'b0;
        tick(4);

        // Reset during XFER of a write: no done, outputs cleared at once.
        m = cyc;
        req = 2'b01; dir = 2'b01; addr0 = 15'h0ABC; wdata0 = 12'o4321;
        cycle_end = 1'b1;
        tick(1);
        req = 2'b00; cycle_end = 1'b0;
        tick(1);
        check("rx_xfer_to_mem", {31'd0, to_mem}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rx_to_mem", {31'd0, to_mem}, 32'd0);
        check("rx_bip", {31'd0, break_in_prog}, 32'd0);
        check("rx_grant", {30'd0, grant}, 32'd0);
        check("rx_done", {30'd0, done}, 32'd0);
        check("rx_addr", {17'd0, dmaAddr}, 32'd0);
        check("rx_rdata", {20'd0, rdata}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(5);

        check("sb_leftover", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/break_arbiter.md
BREAK_ARBITER -- requirements
Module: break_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4: maximum back-to-back data breaks before the CPU is guaranteed one cycle.
REQ-002 clk  in  1  system clock (clk100 domain); one clock only.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 clear  in  1  debounced front-panel clear, synchronous.
REQ-005 cycle_end  in  1  state_machine at a break-eligible major-state boundary.
REQ-006 req  in  2  data-break request per device; bit 0 is the RK8E, bit 1 is spare.
REQ-007 dir  in  2  per-device direction; 1 means device-to-memory (write).
REQ-008 addr0, addr1  in  15  per-device extended memory address {field,addr}.
REQ-009 wdata0, wdata1  in  12  per-device write data.
REQ-010 mdout  in  12  memory read data.
REQ-011 grant  out  2  one-hot grant, held from ADDR through DONE.
REQ-012 break_in_prog  out  1  high in ADDR and XFER; stalls state_machine.
REQ-013 to_mem  out  1  memory write enable, XFER only, when the latched dir is 1.
REQ-014 dmaAddr  out  15  latched winner address.
REQ-015 dmaDOUT  out  12  latched winner write data.
REQ-016 rdata  out  12  read data to devices, valid in DONE and held until the next XFER.
REQ-017 done  out  2  one-cycle completion pulse to the granted device.

Function
REQ-018 The FSM SHALL have states IDLE, ADDR, XFER and DONE, one cycle each outside IDLE.
REQ-019 IDLE -> ADDR when cycle_end=1, req!=0 and the burst guard is not blocking; winner, dir, address and data latch on that edge.
REQ-020 Transitions SHALL be ADDR -> XFER -> DONE -> IDLE unconditionally; break latency from the sampling edge to done is 3 cycles.
REQ-021 Arbitration SHALL use fixed priority, device 0 over device 1, unless BRK_RR_EN is defined.
REQ-022 req SHALL be sampled only in IDLE; a request still high after done counts as a new break.
REQ-023 rdata SHALL capture mdout on the XFER->DONE edge for reads; a write leaves rdata unchanged.
REQ-024 burst_cnt SHALL increment on each ADDR entry and clear on any IDLE cycle with no new break.
REQ-025 When burst_cnt=BURST_MAX, IDLE SHALL refuse one cycle, clear burst_cnt, then resume normal evaluation.
REQ-026 The grant SHALL be evaluated on the clock edge, and a req that drops in the same cycle is ignored.
REQ-027 A clear asserted outside IDLE SHALL let the break finish to DONE, with no abort and no corrupt write.
REQ-028 A clear asserted in IDLE SHALL block new grants that cycle.
REQ-029 dmaAddr and dmaDOUT SHALL be stable from ADDR through DONE.

Reset
REQ-030 Reset SHALL force state=IDLE, grant=0, break_in_prog=0, to_mem=0, done=0, dmaAddr=0, dmaDOUT=0, rdata=0, burst_cnt=0 and RR pointer=0.
REQ-031 Reset mid-break SHALL drop to_mem immediately, with no done pulse.

Configuration
REQ-032 Macro BRK_RR_EN:
- Defined: round-robin arbitration; the pointer advances past the winner at DONE.
- Undefined: fixed priority per REQ-021, and no pointer register is built.

Structure
REQ-033 The shared package brk_pkg SHALL hold the state encoding, NDEV=2, the address width (15), the data width (12) and the default BURST_MAX.
REQ-034 The winner selection SHALL live in one sub-module, brk_prio (fixed/round-robin picker), with combinational output only.

Verification
REQ-035 req=01, dir=1, addr0=0x1234, wdata0=0o7070, cycle_end pulse:
- grant=01 and break_in_prog=1 for 2 cycles.
- to_mem=1 in XFER with dmaAddr=0x1234 and dmaDOUT=0o7070.
- done=01 three cycles after sampling.
REQ-036 req=11 both reads with cycle_end held:
- Fixed priority: device 0, then device 1.
- BRK_RR_EN: device 0, then device 1, then device 0 for continuous requests.
REQ-037 req=01 held with cycle_end held:
- Exactly 4 breaks, then one refused IDLE cycle, then breaks resume.
REQ-038 Read at addr1=0x0200 with mdout=0o5252 -> rdata=0o5252 in DONE and done=10.
REQ-039 Reset asserted in XFER of a write:
- to_mem=0 and state=IDLE asynchronously, with no done pulse.
- clear in ADDR: the break completes with done=01.
